// File: rtl/pll_lock_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Module   : pll_lock_sequencer_if
//  Purpose  : Lock inputs, fault clear and sequencer status/outputs bundle.
//  Revision : 1.0  initial release
// ============================================================================
interface pll_lock_sequencer_if #(
   parameter int MAX_RETRIES = 3
) ();
   localparam int c_rw = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1;

   logic            locked_pll_0;
   logic            locked_pll_1;
   logic            fault_clr;
   logic            pll1_resetb;
   logic            sys_rst_n;
   logic            fault;
   logic [c_rw-1:0] retry_count;
   logic [2:0]      state;

   modport master (
      output locked_pll_0, locked_pll_1, fault_clr,
      input  pll1_resetb, sys_rst_n, fault, retry_count, state
   );

   modport slave (
      input  locked_pll_0, locked_pll_1, fault_clr,
      output pll1_resetb, sys_rst_n, fault, retry_count, state
   );
endinterface
`default_nettype wire

// File: rtl/pll_lock_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : pll_lock_sequencer
//  Purpose  : Brings up the PLL0 -> PLL1 chain, releases system reset once
//             both locks are stable, retries PLL1 and latches a fault.
//  Revision : 1.0  initial release
// ============================================================================
module pll_lock_sequencer #(
   parameter int LOCK_STABLE_CYCLES = 2500,
   parameter int PLL1_RESET_CYCLES  = 25,
   parameter int TIMEOUT_CYCLES     = 25000,
   parameter int MAX_RETRIES        = 3
) (
   input  logic                clk_25MHz,
   input  logic                rst_n,
   pll_lock_sequencer_if.slave bus
);
   localparam int c_rw  = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1;
   localparam int c_scw = (LOCK_STABLE_CYCLES > 1) ? $clog2(LOCK_STABLE_CYCLES) : 1;
   localparam int c_gcw = $clog2(TIMEOUT_CYCLES + 1);

   localparam logic [c_scw-1:0] c_sc_last      = c_scw'(LOCK_STABLE_CYCLES - 1);
   localparam logic [c_gcw-1:0] c_gc_hold_last = c_gcw'(PLL1_RESET_CYCLES - 1);
   localparam logic [c_gcw-1:0] c_gc_tout_last = c_gcw'(TIMEOUT_CYCLES - 1);
   localparam logic [c_rw-1:0]  c_retry_max    = c_rw'(MAX_RETRIES);

   typedef enum logic [2:0] {
      WAIT_P0 = 3'd0,
      HOLD_P1 = 3'd1,
      WAIT_P1 = 3'd2,
      RUN     = 3'd3,
      FAULT   = 3'd4
   } state_t;

   logic             r_l0_meta, r_l0s, r_l1_meta, r_l1s;
   state_t           r_state, w_next_state;
   logic [c_scw-1:0] r_sc;
   logic [c_gcw-1:0] r_gc;
   logic [c_rw-1:0]  r_retry_count, w_next_retry;
   logic             r_pll1_resetb, r_sys_rst_n, r_fault;
   logic             w_next_pll1_resetb, w_next_sys_rst_n, w_next_fault;
   logic             w_watching, w_lock_mon, w_stable, w_retry, w_state_change;

   always_ff @(posedge clk_25MHz or negedge rst_n) begin
      if (!rst_n) begin
         r_l0_meta <= 1'b0;
         r_l0s     <= 1'b0;
         r_l1_meta <= 1'b0;
         r_l1s     <= 1'b0;
      end else begin
         r_l0_meta <= bus.locked_pll_0;
         r_l0s     <= r_l0_meta;
         r_l1_meta <= bus.locked_pll_1;
         r_l1s     <= r_l1_meta;
      end
   end

   // Only the two WAIT states qualify a lock; WAIT_P1 watches PLL1, WAIT_P0 PLL0.
   assign w_watching     = (r_state == WAIT_P0) || (r_state == WAIT_P1);
   assign w_lock_mon     = (r_state == WAIT_P1) ? r_l1s : r_l0s;
   assign w_stable       = w_watching && w_lock_mon && (r_sc == c_sc_last);
   assign w_state_change = (w_next_state != r_state);

   always_comb begin
      w_next_state = r_state;
      w_next_retry = r_retry_count;
      w_retry      = 1'b0;
      case (r_state)
         WAIT_P0: begin
            if (w_stable) w_next_state = HOLD_P1;
         end
         HOLD_P1: begin
            if (!r_l0s)                    w_next_state = WAIT_P0;
            else if (r_gc == c_gc_hold_last) w_next_state = WAIT_P1;
         end
         WAIT_P1: begin
            // PLL0 loss wins, and a lock reaching stability beats a timeout.
            if (!r_l0s)                      w_next_state = WAIT_P0;
            else if (w_stable)               w_next_state = RUN;
            else if (r_gc == c_gc_tout_last) w_retry      = 1'b1;
         end
         RUN: begin
            if (!r_l0s)      w_next_state = WAIT_P0;
            else if (!r_l1s) w_retry      = 1'b1;
         end
         FAULT: begin
            if (bus.fault_clr) begin
               w_next_state = WAIT_P0;
               w_next_retry = '0;
            end
         end
         default: w_next_state = WAIT_P0;
      endcase

      if (w_retry) begin
         if (r_retry_count == c_retry_max) begin
            w_next_state = FAULT;
         end else begin
            w_next_retry = r_retry_count + c_rw'(1);
            w_next_state = HOLD_P1;
         end
      end

      w_next_pll1_resetb = (w_next_state == WAIT_P1) || (w_next_state == RUN);
      w_next_sys_rst_n   = (w_next_state == RUN);
      w_next_fault       = (w_next_state == FAULT);
   end

   always_ff @(posedge clk_25MHz or negedge rst_n) begin
      if (!rst_n) begin
         r_state       <= WAIT_P0;
         r_retry_count <= '0;
         r_pll1_resetb <= 1'b0;
         r_sys_rst_n   <= 1'b0;
         r_fault       <= 1'b0;
      end else begin
         r_state       <= w_next_state;
         r_retry_count <= w_next_retry;
         r_pll1_resetb <= w_next_pll1_resetb;
         r_sys_rst_n   <= w_next_sys_rst_n;
         r_fault       <= w_next_fault;
      end
   end

   always_ff @(posedge clk_25MHz or negedge rst_n) begin
      if (!rst_n) begin
         r_sc <= '0;
         r_gc <= '0;
      end else begin
         if (w_state_change)              r_sc <= '0;
         else if (w_watching && w_lock_mon) r_sc <= r_sc + c_scw'(1);
         else                             r_sc <= '0;

         if (w_state_change)                                 r_gc <= '0;
         else if ((r_state == HOLD_P1) || (r_state == WAIT_P1)) r_gc <= r_gc + c_gcw'(1);
         else                                                r_gc <= '0;
      end
   end

   assign bus.pll1_resetb = r_pll1_resetb;
   assign bus.sys_rst_n   = r_sys_rst_n;
   assign bus.fault       = r_fault;
   assign bus.retry_count = r_retry_count;
   assign bus.state       = r_state;
endmodule
`default_nettype wire

// File: tb/tb_pll_lock_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pll_lock_sequencer
//  Purpose  : Self-checking bench: vector table, corner sequences, random run.
//  Revision : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
module tb_pll_lock_sequencer;
   localparam int L  = 8;
   localparam int P  = 4;
   localparam int T  = 64;
   localparam int M  = 2;
   localparam int RW = $clog2(M + 1);

   logic clk_25MHz = 1'b0;
   logic rst_n     = 1'b1;
   always #5 clk_25MHz = ~clk_25MHz;

   pll_lock_sequencer_if #(.MAX_RETRIES(M)) bus ();

   pll_lock_sequencer #(
      .LOCK_STABLE_CYCLES(L),
      .PLL1_RESET_CYCLES (P),
      .TIMEOUT_CYCLES    (T),
      .MAX_RETRIES       (M)
   ) dut (
      .clk_25MHz(clk_25MHz),
      .rst_n    (rst_n),
      .bus      (bus)
   );

   int nchecks = 0;
   int nerr    = 0;
   int cyc     = 0;

   // Reference: mode number per the state list, samples seen through a 2-deep delay line.
   int         m_state, m_age, m_run, m_retry;
   logic [1:0] m_dly0, m_dly1;

   function automatic void model_reset();
      m_state = 0; m_age = 0; m_run = 0; m_retry = 0;
      m_dly0  = '0; m_dly1 = '0;
   endfunction

   task automatic model_step();
      logic l0, l1, watch, mon, stable, retry;
      int   nxt;
      if (!rst_n) begin
         model_reset();
         return;
      end
      l0     = m_dly0[1];
      l1     = m_dly1[1];
      watch  = (m_state == 0) || (m_state == 2);
      mon    = (m_state == 2) ? l1 : l0;
      stable = watch && mon && (m_run + 1 >= L);
      nxt    = m_state;
      retry  = 1'b0;
      case (m_state)
         0: if (stable) nxt = 1;
         1: if (!l0) nxt = 0; else if (m_age + 1 >= P) nxt = 2;
         2: if (!l0) nxt = 0; else if (stable) nxt = 3; else if (m_age + 1 >= T) retry = 1'b1;
         3: if (!l0) nxt = 0; else if (!l1) retry = 1'b1;
         4: if (bus.fault_clr) begin nxt = 0; m_retry = 0; end
         default: nxt = 0;
      endcase
      if (retry) begin
         if (m_retry >= M) nxt = 4;
         else begin m_retry = m_retry + 1; nxt = 1; end
      end
      if (nxt != m_state) begin
         m_age = 0; m_run = 0;
      end else begin
         m_age = m_age + 1;
         m_run = (watch && mon) ? m_run + 1 : 0;
      end
      m_state = nxt;
      m_dly0  = {m_dly0[0], bus.locked_pll_0};
      m_dly1  = {m_dly1[0], bus.locked_pll_1};
   endtask

   task automatic check_eq(input string name, input logic [31:0] act, input logic [31:0] exp);
      nchecks++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic check_model();
      logic [5+RW:0] act, exp;
      act = {bus.state, bus.pll1_resetb, bus.sys_rst_n, bus.fault, bus.retry_count};
      exp = {3'(m_state), (m_state == 2 || m_state == 3), (m_state == 3), (m_state == 4), RW'(m_retry)};
      check_eq($sformatf("model cyc%0d {state,pll1_resetb,sys_rst_n,fault,retry}", cyc), act, exp);
   endtask

   task automatic tick();
      @(posedge clk_25MHz);
      model_step();
      #1;
      cyc++;
      check_model();
   endtask

   task automatic async_reset();
      rst_n = 1'b0;
      model_reset();
      #1;
      check_eq("async reset state", bus.state, 0);
      check_eq("async reset pll1_resetb", bus.pll1_resetb, 0);
      check_eq("async reset sys_rst_n", bus.sys_rst_n, 0);
      check_eq("async reset fault", bus.fault, 0);
      check_eq("async reset retry_count", bus.retry_count, 0);
   endtask

   task automatic drive(input logic l0, input logic l1, input logic fc);
      bus.locked_pll_0 = l0;
      bus.locked_pll_1 = l1;
      bus.fault_clr    = fc;
   endtask

   typedef struct {
      logic l0; logic l1; logic fc; int n;
      int st; logic pr; logic sr; int rc;
   } vec_t;

   function automatic vec_t mk(logic l0, logic l1, logic fc, int n, int st, logic pr, logic sr, int rc);
      vec_t v;
      v.l0 = l0; v.l1 = l1; v.fc = fc; v.n = n;
      v.st = st; v.pr = pr; v.sr = sr; v.rc = rc;
      return v;
   endfunction

   typedef struct { int c; int st; int rc; logic flt; } cp_t;

   function automatic cp_t mkcp(int c, int st, int rc, logic flt);
      cp_t p;
      p.c = c; p.st = st; p.rc = rc; p.flt = flt;
      return p;
   endfunction

   vec_t tv[$];
   cp_t  cps[$];

   initial begin
      // Bring-up, PLL1 loss in RUN, fault_clr ignored in RUN, PLL0 loss, PLL0 glitch.
      tv.push_back(mk(1,0,0,9, 0,0,0,0));
      tv.push_back(mk(1,0,0,1, 1,0,0,0));
      tv.push_back(mk(1,0,0,3, 1,0,0,0));
      tv.push_back(mk(1,0,0,1, 2,1,0,0));
      tv.push_back(mk(1,0,0,9, 2,1,0,0));
      tv.push_back(mk(1,1,0,9, 2,1,0,0));
      tv.push_back(mk(1,1,0,1, 3,1,1,0));
      tv.push_back(mk(1,0,0,2, 3,1,1,0));
      tv.push_back(mk(1,0,0,1, 1,0,0,1));
      tv.push_back(mk(1,1,0,3, 1,0,0,1));
      tv.push_back(mk(1,1,0,1, 2,1,0,1));
      tv.push_back(mk(1,1,0,7, 2,1,0,1));
      tv.push_back(mk(1,1,0,1, 3,1,1,1));
      tv.push_back(mk(1,1,1,1, 3,1,1,1));
      tv.push_back(mk(0,1,0,2, 3,1,1,1));
      tv.push_back(mk(0,1,0,1, 0,0,0,1));
      tv.push_back(mk(1,1,0,5, 0,0,0,1));
      tv.push_back(mk(0,1,0,1, 0,0,0,1));
      tv.push_back(mk(1,1,0,9, 0,0,0,1));
      tv.push_back(mk(1,1,0,1, 1,0,0,1));

      // PLL1 never locks: edges counted from reset release with PLL0 already up.
      cps.push_back(mkcp( 10, 1, 0, 0));
      cps.push_back(mkcp( 13, 1, 0, 0));
      cps.push_back(mkcp( 14, 2, 0, 0));
      cps.push_back(mkcp( 77, 2, 0, 0));
      cps.push_back(mkcp( 78, 1, 1, 0));
      cps.push_back(mkcp( 82, 2, 1, 0));
      cps.push_back(mkcp(145, 2, 1, 0));
      cps.push_back(mkcp(146, 1, 2, 0));
      cps.push_back(mkcp(150, 2, 2, 0));
      cps.push_back(mkcp(213, 2, 2, 0));
      cps.push_back(mkcp(214, 4, 2, 1));

      drive(0, 0, 0);
      model_reset();
      #2;
      async_reset();
      tick();
      tick();
      rst_n = 1'b1;
      tick();
      tick();

      foreach (tv[i]) begin
         drive(tv[i].l0, tv[i].l1, tv[i].fc);
         for (int k = 0; k < tv[i].n; k++) tick();
         check_eq($sformatf("vec%0d state", i), bus.state, tv[i].st);
         check_eq($sformatf("vec%0d pll1_resetb", i), bus.pll1_resetb, tv[i].pr);
         check_eq($sformatf("vec%0d sys_rst_n", i), bus.sys_rst_n, tv[i].sr);
         check_eq($sformatf("vec%0d retry_count", i), bus.retry_count, tv[i].rc);
         check_eq($sformatf("vec%0d fault", i), bus.fault, 0);
      end

      // PLL1 timeouts exhaust retries and latch FAULT.
      drive(1, 0, 0);
      async_reset();
      tick();
      tick();
      rst_n = 1'b1;
      begin
         int k = 0;
         for (int c = 1; c <= 214; c++) begin
            tick();
            if (k < cps.size() && cps[k].c == c) begin
               check_eq($sformatf("timeout c%0d state", c), bus.state, cps[k].st);
               check_eq($sformatf("timeout c%0d retry_count", c), bus.retry_count, cps[k].rc);
               check_eq($sformatf("timeout c%0d fault", c), bus.fault, cps[k].flt);
               check_eq($sformatf("timeout c%0d pll1_resetb", c), bus.pll1_resetb,
                        (cps[k].st == 2 || cps[k].st == 3));
               k++;
            end
         end
      end
      drive(1, 1, 0);
      for (int k = 0; k < 5; k++) tick();
      check_eq("fault held state", bus.state, 4);
      check_eq("fault held pll1_resetb", bus.pll1_resetb, 0);
      drive(1, 1, 1);
      tick();
      drive(1, 1, 0);
      check_eq("fault_clr state", bus.state, 0);
      check_eq("fault_clr retry_count", bus.retry_count, 0);
      check_eq("fault_clr fault", bus.fault, 0);

      // Asynchronous reset in the middle of WAIT_P1.
      for (int k = 0; k < 12; k++) tick();
      check_eq("pre-reset state", bus.state, 2);
      check_eq("pre-reset pll1_resetb", bus.pll1_resetb, 1);
      tick();
      tick();
      #2;
      async_reset();
      tick();
      rst_n = 1'b1;

      // Random lock behaviour against the reference.
      begin
         logic l0, l1, fc;
         l0 = 1'b0; l1 = 1'b0;
         for (int c = 0; c < 3000; c++) begin
            if (l0) l0 = ($urandom_range(0, 149) != 0);
            else    l0 = ($urandom_range(0, 5) == 0);
            if (l1) l1 = ($urandom_range(0, 59) != 0);
            else    l1 = ($urandom_range(0, 39) == 0);
            fc = ($urandom_range(0, 39) == 0);
            drive(l0, l1, fc);
            if ($urandom_range(0, 799) == 0) begin
               async_reset();
               tick();
               rst_n = 1'b1;
            end
            tick();
         end
      end

      $display("Result: errors=%0d of %0d checks", nerr, nchecks);
      $finish;
   end
endmodule
`default_nettype wire

// File: doc/pll_lock_sequencer.md
Name: pll_lock_sequencer

Overview:
- Sequences bring-up of the cascaded PLL chain: 25 MHz -> 100 MHz (PLL0) -> 96/12 MHz (PLL1).
- Holds PLL1 in reset until PLL0 lock is stable, then waits for stable PLL1 lock before releasing the system reset.
- Runs on the always-present 25 MHz reference clock. Handles lock loss and lock timeouts with bounded retries, and latches a fault when retries are exhausted.

Parameters:
- LOCK_STABLE_CYCLES, 2500: consecutive synchronized lock-high cycles required to declare lock (100 us).
- PLL1_RESET_CYCLES, 25: minimum PLL1 reset pulse length in cycles (1 us).
- TIMEOUT_CYCLES, 25000: maximum cycles in WAIT_P1 before a retry (1 ms).
- MAX_RETRIES, 3: PLL1 retries allowed before FAULT.

Ports:
- clk_25MHz, input, 1: reference clock; the only clock in this block.
- rst_n, input, 1: asynchronous, active-low reset.
- locked_pll_0, input, 1: PLL0 lock; asynchronous, synchronized internally.
- locked_pll_1, input, 1: PLL1 lock; asynchronous, synchronized internally.
- fault_clr, input, 1: synchronous pulse; leaves FAULT and clears retry_count.
- pll1_resetb, output, 1: active-low reset to PLL1.
- sys_rst_n, output, 1: active-low system reset request. Downstream domains must resynchronize it.
- fault, output, 1: high while in FAULT.
- retry_count, output, RW = clog2(MAX_RETRIES+1): retries consumed.
- state, output, 3: current state encoding, for debug.

Behaviour:
- Interface: one clock (clk_25MHz); reset rst_n is asynchronous and active-low. All outputs and state are registered.
- Reset values: state=WAIT_P0 (0), pll1_resetb=0, sys_rst_n=0, fault=0, retry_count=0, all counters=0, sync flops=0.
- Synchronization: each lock input passes through a 2-flop synchronizer; l0s and l1s are the second-stage outputs.
- Stable counter (sc):
  - Increments while the monitored lock's sync output is 1; clears to 0 the cycle it is 0.
  - Lock is "stable" when sc == LOCK_STABLE_CYCLES-1 and the sync output is 1.
  - sc clears on every state change.
- General counter (gc): clears on every state change; increments by 1 per cycle in HOLD_P1 and WAIT_P1. Width = clog2(TIMEOUT_CYCLES+1).
- States and outputs:
  - WAIT_P0 (0): pll1_resetb=0, sys_rst_n=0. Monitors l0s. When PLL0 is stable -> HOLD_P1.
  - HOLD_P1 (1): pll1_resetb=0, sys_rst_n=0.
    - l0s=0 -> WAIT_P0.
    - Else, when gc == PLL1_RESET_CYCLES-1 -> WAIT_P1.
  - WAIT_P1 (2): pll1_resetb=1, sys_rst_n=0. Monitors l1s.
    - l0s=0 -> WAIT_P0 (no retry charged).
    - PLL1 stable -> RUN.
    - gc == TIMEOUT_CYCLES-1 -> retry.
  - RUN (3): pll1_resetb=1, sys_rst_n=1.
    - l0s=0 -> WAIT_P0.
    - Else l1s=0 -> retry.
  - FAULT (4): pll1_resetb=0, sys_rst_n=0, fault=1. Exits only via rst_n, or fault_clr=1 -> WAIT_P0 with retry_count=0.
- Retry rule: if retry_count == MAX_RETRIES, go to FAULT; else increment retry_count and go to HOLD_P1.
- retry_count clears only on rst_n or fault_clr; it does not clear on reaching RUN.
- Priority: PLL0 loss beats a PLL1 event in the same cycle. A timeout and PLL1-stable in the same cycle resolves as stable.
- Output timing: registered outputs change in the same cycle as the state register, i.e. one cycle after the deciding condition is sampled.
- Latency: a clean locked_pll_0 rise reaches HOLD_P1 after 2 + LOCK_STABLE_CYCLES clock edges.
- Glitch handling: a one-cycle drop of l0s or l1s during counting restarts the count from 0.
- fault_clr is ignored outside FAULT.
- Reset mid-operation: rst_n asserted in any state immediately forces the reset values, including pll1_resetb=0 and sys_rst_n=0.

Test Plan:
Bench parameters: LOCK_STABLE_CYCLES=8, PLL1_RESET_CYCLES=4, TIMEOUT_CYCLES=64, MAX_RETRIES=2.
1. Clean bring-up: release rst_n, raise locked_pll_0 at t0 and locked_pll_1 10 cycles after pll1_resetb rises.
   -> HOLD_P1 at t0+10; pll1_resetb=1 after 4 cycles in HOLD_P1; sys_rst_n=1 after 2+8 cycles of l1 high; retry_count=0.
2. Glitchy PLL0 lock: locked_pll_0 high 5 cycles, low 1 cycle, then high.
   -> count restarts; HOLD_P1 reached 10 cycles after the final rise; pll1_resetb stays 0 throughout.
3. PLL1 loss in RUN: drop locked_pll_1 for 3 cycles.
   -> 3 cycles after the drop (2 sync + 1 registered), sys_rst_n=0, state=HOLD_P1, retry_count=1. RUN is re-entered after the relock sequence.
4. PLL1 never locks: keep locked_pll_1=0.
   -> three 64-cycle timeouts; retry_count goes 1, 2; third timeout gives state=FAULT, fault=1, pll1_resetb=0. Pulse fault_clr -> WAIT_P0, retry_count=0, fault=0.
5. PLL0 loss in RUN with locked_pll_1 held high: drop locked_pll_0.
   -> WAIT_P0, pll1_resetb=0, sys_rst_n=0, retry_count unchanged.
6. Async reset mid-WAIT_P1: assert rst_n between clock edges.
   -> all outputs take reset values immediately, without waiting for a clock edge.
